// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory: access-size encoding,
// controller states and lane helpers used by both the control and lane-steering logic.
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Low address bits that are meaningless for the access size are dropped.
    function automatic logic [1:0] align_lane(size_e s, logic [1:0] lane);
        case (s)
            SZ_HALF: return {lane[1], 1'b0};
            SZ_WORD: return 2'b00;
            default: return lane;
        endcase
    endfunction

    function automatic logic misaligned(size_e s, logic [1:0] lane);
        return ((s == SZ_HALF) && lane[0]) || ((s == SZ_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bus of the data memory: valid/ready request channel and
// a one-cycle response pulse carrying load data and the fault flag.
interface data_memory_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  rsp_valid;
    logic [31:0]           rdata;
    logic                  fault;

    modport master (
        output req_valid, req_write, req_size, req_signed, addr, wdata,
        input  req_ready, rsp_valid, rdata, fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, addr, wdata,
        output req_ready, rsp_valid, rdata, fault
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store side builds the byte-enable mask and lane-shifted
// data; load side picks the addressed lanes and sign/zero extends. Lanes arrive pre-aligned.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       st_size_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_sh_o,
    input  size_e       ld_size_i,
    input  logic [1:0]  ld_lane_i,
    input  logic        ld_signed_i,
    input  logic [31:0] rword_i,
    output logic [31:0] ld_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be_o       = 4'b0000;
        wdata_sh_o = 32'h0;
        case (st_size_i)
            SZ_BYTE: begin
                be_o       = 4'b0001 << st_lane_i;
                wdata_sh_o = {24'h0, wdata_i[7:0]} << {st_lane_i, 3'b000};
            end
            SZ_HALF: begin
                be_o       = 4'b0011 << st_lane_i;
                wdata_sh_o = {16'h0, wdata_i[15:0]} << {st_lane_i, 3'b000};
            end
            SZ_WORD: begin
                be_o       = 4'b1111;
                wdata_sh_o = wdata_i;
            end
            default: begin
                be_o       = 4'b0000;
                wdata_sh_o = 32'h0;
            end
        endcase
    end

    always_comb begin
        ld_byte   = rword_i[{ld_lane_i, 3'b000} +: 8];
        ld_half   = rword_i[{ld_lane_i[1], 4'b0000} +: 16];
        ld_data_o = 32'h0;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = {{24{ld_signed_i & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_o = {{16{ld_signed_i & ld_half[15]}}, ld_half};
            SZ_WORD: ld_data_o = rword_i;
            default: ld_data_o = 32'h0;
        endcase
    end
endmodule

// File: rtl/data_memory_unit.sv
// MEM-stage data memory: request FSM with wait states, byte-lane RAM and fault detection.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of force-aligning.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    data_memory_unit_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    // With no wait states the array is accessed on the accepting edge, straight from the bus.
    localparam bit DIRECT = (WAIT_STATES == 0);
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  write_q, signed_q;
    size_e                 size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic                  accept, access_en;
    logic                  src_write, src_fault;
    size_e                 src_size;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [31:0]           src_wdata;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            be;
    logic [31:0]           wdata_sh, rword, ld_data;
    logic                  rsp_fault;

    function automatic logic access_fault(logic [ADDR_WIDTH-1:0] a, size_e s);
        return ({2'b00, a[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH))
            || (s == SZ_RSVD)
            || (ALIGN_CHECK && misaligned(s, a[1:0]));
    endfunction

    assign bus.req_ready = (state_q != ST_BUSY);
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        access_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (!accept) begin
                    state_d = ST_IDLE;
                end else if (DIRECT) begin
                    state_d   = ST_RESP;
                    access_en = 1'b1;
                end else begin
                    state_d    = ST_BUSY;
                    wait_cnt_d = 4'(WAIT_STATES - 1);
                end
            end
            ST_BUSY: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d   = ST_RESP;
                    access_en = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= SZ_BYTE;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                write_q  <= bus.req_write;
                signed_q <= bus.req_signed;
                size_q   <= size_e'(bus.req_size);
                addr_q   <= bus.addr;
                wdata_q  <= bus.wdata;
            end
        end
    end

    assign src_write = DIRECT ? bus.req_write : write_q;
    assign src_size  = DIRECT ? size_e'(bus.req_size) : size_q;
    assign src_addr  = DIRECT ? bus.addr : addr_q;
    assign src_wdata = DIRECT ? bus.wdata : wdata_q;
    assign src_fault = access_fault(src_addr, src_size);
    assign idx       = src_addr[IDX_W+1:2];

    // The capture registers always describe the request whose response is being presented.
    assign rsp_fault = access_fault(addr_q, size_q);

    dmem_lane_align u_lane_align (
        .st_size_i   (src_size),
        .st_lane_i   (align_lane(src_size, src_addr[1:0])),
        .wdata_i     (src_wdata),
        .be_o        (be),
        .wdata_sh_o  (wdata_sh),
        .ld_size_i   (size_q),
        .ld_lane_i   (align_lane(size_q, addr_q[1:0])),
        .ld_signed_i (signed_q),
        .rword_i     (rword),
        .ld_data_o   (ld_data)
    );

    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rbyte_q;

        // Gated by reset so nothing reaches the array while the controller is held idle.
        always_ff @(posedge clk) begin
            if (access_en && reset && !src_fault) begin
                if (src_write) begin
                    if (be[gi]) begin
                        mem[idx] <= wdata_sh[8*gi +: 8];
                    end
                end else begin
                    rbyte_q <= mem[idx];
                end
            end
        end

        assign rword[8*gi +: 8] = rbyte_q;
    end

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.fault     = bus.rsp_valid && rsp_fault;
    assign bus.rdata     = (bus.rsp_valid && !rsp_fault && !write_q) ? ld_data : 32'h0;
endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: two instances (0 and 3 wait states) share a random
// request stream; a byte-level reference model predicts every response and its cycle.
module tb_data_memory_unit;
    localparam int AW    = 32;
    localparam int DEPTH = 32;
    localparam int WS0   = 0;
    localparam int WS3   = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst0_n = 1'b1;
    logic rst3_n = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_acc3 = -1000;
    exp_t q0[$];
    exp_t q3[$];
    logic [7:0] mdl [2][DEPTH*4];

    data_memory_unit_if #(.ADDR_WIDTH(AW)) if0 ();
    data_memory_unit_if #(.ADDR_WIDTH(AW)) if3 ();

    data_memory_unit #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .reset(rst0_n), .bus(if0.slave)
    );
    data_memory_unit #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(WS3)) dut3 (
        .clk(clk), .reset(rst3_n), .bus(if3.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference behaviour computed from byte addresses, not from lanes/masks.
    function automatic exp_t model(input int d, input logic w, input logic [1:0] sz,
                                   input logic sg, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int n, ea;
        logic [31:0] v;
        e.rdata = 32'h0;
        e.fault = ((a >> 2) >= DEPTH) || (sz == 2'b11);
        e.cyc   = 0;
`ifdef DMEM_ALIGN_CHECK_EN
        if (sz == 2'b01 && a[0]) e.fault = 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00) e.fault = 1'b1;
`endif
        if (e.fault) return e;
        n  = 1 << sz;
        ea = int'(a) & ~(n - 1);
        if (w) begin
            for (int k = 0; k < n; k++) mdl[d][ea+k] = 8'(wd >> (8*k));
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(mdl[d][ea+k]) << (8*k));
            if (sg && n == 1 && v[7])  v = v | 32'hFFFFFF00;
            if (sg && n == 2 && v[15]) v = v | 32'hFFFF0000;
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic issue(input bit u0, input bit u3, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input bit discard);
        exp_t e0, e3;
        bit p0, p3, a0, a3;
        int guard;
        p0 = u0; p3 = u3; guard = 0;
        if (u0 && !discard) e0 = model(0, w, sz, sg, a, wd);
        if (u3 && !discard) e3 = model(1, w, sz, sg, a, wd);
        if0.req_write = w; if0.req_size = sz; if0.req_signed = sg; if0.addr = a; if0.wdata = wd;
        if3.req_write = w; if3.req_size = sz; if3.req_signed = sg; if3.addr = a; if3.wdata = wd;
        if0.req_valid = u0;
        if3.req_valid = u3;
        while ((p0 || p3) && guard < 100) begin
            @(negedge clk);
            a0 = p0 && if0.req_ready && rst0_n;
            a3 = p3 && if3.req_ready && rst3_n;
            if (a0) begin
                e0.cyc = cyc + 1 + WS0;
                if (!discard) q0.push_back(e0);
            end
            if (a3) begin
                e3.cyc = cyc + 1 + WS3;
                if (!discard) q3.push_back(e3);
                last_acc3 = cyc;
            end
            @(posedge clk);
            #1;
            if (a0) begin if0.req_valid = 1'b0; p0 = 1'b0; end
            if (a3) begin if3.req_valid = 1'b0; p3 = 1'b0; end
            guard++;
        end
        if (p0 || p3) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: pending dut0=%0b dut3=%0b addr=%h", p0, p3, a);
            if0.req_valid = 1'b0;
            if3.req_valid = 1'b0;
        end
    endtask

    task automatic both(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
        issue(1'b1, 1'b1, w, sz, sg, a, wd, 1'b0);
    endtask

    // Response monitors: pop the oldest expectation whenever a response pulse appears.
    always @(negedge clk) begin
        exp_t e;
        if (rst0_n) begin
            chk("dut0_ready", 32'(if0.req_ready), 32'd1);
            if (if0.rsp_valid) begin
                if (q0.size() == 0) begin
                    chk("dut0_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    $display("dut0 rsp cyc=%0d rdata=%h fault=%0b", cyc, if0.rdata, if0.fault);
                    chk("dut0_rsp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("dut0_rdata", if0.rdata, e.rdata);
                    chk("dut0_fault", 32'(if0.fault), 32'(e.fault));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        if (rst3_n) begin
            exp_rdy = !((cyc >= last_acc3 + 1) && (cyc <= last_acc3 + WS3));
            chk("dut3_ready", 32'(if3.req_ready), 32'(exp_rdy));
            if (if3.rsp_valid) begin
                if (q3.size() == 0) begin
                    chk("dut3_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q3.pop_front();
                    $display("dut3 rsp cyc=%0d rdata=%h fault=%0b", cyc, if3.rdata, if3.fault);
                    chk("dut3_rsp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("dut3_rdata", if3.rdata, e.rdata);
                    chk("dut3_fault", 32'(if3.fault), 32'(e.fault));
                end
            end
        end
    end

    initial begin
        logic w, sg;
        logic [1:0] sz;
        logic [31:0] a;
        if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_size = 2'b00;
        if0.req_signed = 1'b0; if0.addr = '0; if0.wdata = '0;
        if3.req_valid = 1'b0; if3.req_write = 1'b0; if3.req_size = 2'b00;
        if3.req_signed = 1'b0; if3.addr = '0; if3.wdata = '0;

        #1;
        rst0_n = 1'b0;
        rst3_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid0", 32'(if0.rsp_valid), 32'd0);
        chk("reset_rdata0", if0.rdata, 32'h0);
        chk("reset_fault0", 32'(if0.fault), 32'd0);
        chk("reset_ready3", 32'(if3.req_ready), 32'd1);
        chk("reset_rsp_valid3", 32'(if3.rsp_valid), 32'd0);
        @(negedge clk);
        rst0_n = 1'b1;
        rst3_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) both(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);

        both(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        both(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        both(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
        both(1'b1, 2'b00, 1'b0, 32'h13, 32'h80);
        both(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        both(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        both(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        both(1'b0, 2'b10, 1'b0, 32'(DEPTH * 4), 32'h0);
        both(1'b1, 2'b10, 1'b0, 32'(DEPTH * 4), 32'h55555555);
        both(1'b0, 2'b10, 1'b0, 32'(DEPTH * 4 - 4), 32'h0);
        both(1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
        both(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234);
        both(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        both(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D);
        both(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        both(1'b0, 2'b11, 1'b0, 32'h30, 32'h0);

        // Reset in the middle of a wait-stated store must drop the store.
        issue(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 1'b0);
        issue(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        repeat (WS3 + 2) @(posedge clk);
        #1;
        issue(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hAAAAAAAA, 1'b1);
        rst3_n = 1'b0;
        last_acc3 = -1000;
        #1;
        chk("busy_reset_rsp_valid", 32'(if3.rsp_valid), 32'd0);
        chk("busy_reset_rdata", if3.rdata, 32'h0);
        chk("busy_reset_fault", 32'(if3.fault), 32'd0);
        chk("busy_reset_ready", 32'(if3.req_ready), 32'd1);
        @(negedge clk);
        rst3_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) a = 32'(DEPTH * 4 + $urandom_range(0, 255));
            else if ($urandom_range(0, 31) == 0) a = $urandom;
            else a = 32'($urandom_range(0, DEPTH * 4 - 1));
            both(w, sz, sg, a, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (10) @(posedge clk);
        #1;
        chk("dut0_drained", 32'(q0.size()), 32'd0);
        chk("dut3_drained", 32'(q3.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
